// File: rtl/joystick_dir_decoder.sv
// joystick_dir_decoder
// Polls an MCP3008 driver at a fixed rate, turns each x/y sample into a signed offset
// from centre, applies a deadzone, debounces the result and reports a 4-way direction.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   adc_start    1-cycle start request to the ADC driver
//   x_data_in    10-bit x sample, valid with data_valid
//   y_data_in    10-bit y sample, valid with data_valid
//   data_valid   1-cycle strobe from the ADC driver
//   dx, dy       signed 11-bit offsets (sample - CENTER), registered
//   dir          committed direction {up,down,left,right}, one-hot or 0 for centre
//   dir_changed  1-cycle pulse when dir takes a new value
//   timeout      1-cycle pulse when the ADC fails to answer within TIMEOUT cycles
//   fault        sticky timeout flag, cleared by the next accepted sample
//
// Optional feature: define JOY_AVG_EN to run each axis through a 4-sample moving
// average (window preloaded with CENTER) before the offset stage; adds one cycle.

module joystick_dir_decoder #(
    parameter int unsigned SAMPLE_DIV = 500000,
    parameter int unsigned TIMEOUT    = 2000,
    parameter int unsigned CENTER     = 512,
    parameter int unsigned DEADZONE   = 96,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        adc_start,
    input  logic [9:0]  x_data_in,
    input  logic [9:0]  y_data_in,
    input  logic        data_valid,
    output logic [10:0] dx,
    output logic [10:0] dy,
    output logic [3:0]  dir,
    output logic        dir_changed,
    output logic        timeout,
    output logic        fault
);

    localparam int unsigned TickW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [10:0] CenterW = 11'(CENTER);
    localparam logic [10:0] DzW     = 11'(DEADZONE);
    localparam logic [3:0]  StableW = 4'(STABLE_CNT);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
`ifdef JOY_AVG_EN
        StAvg,
`endif
        StCalc,
        StCommit
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q;
    logic              tick;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              start_d, timeout_d, fault_d, changed_d;
    logic [9:0]        xs_q, xs_d, ys_q, ys_d;
    logic [10:0]       dx_d, dy_d;
    logic [3:0]        raw_q, raw_d, cand_q, cand_d, cnt_q, cnt_d, dir_d;
    logic [10:0]       dx_c, dy_c, adx, ady;
    logic              x_def, y_def;
    logic [3:0]        raw_c;

`ifdef JOY_AVG_EN
    logic [3:0][9:0]   xw_q, xw_d, yw_q, yw_d;
    logic [11:0]       xsum, ysum;

    assign xsum = 12'(xw_q[0]) + 12'(xw_q[1]) + 12'(xw_q[2]) + 12'(xw_q[3]);
    assign ysum = 12'(yw_q[0]) + 12'(yw_q[1]) + 12'(yw_q[2]) + 12'(yw_q[3]);
`endif

    assign tick = (tick_q == TickW'(SAMPLE_DIV - 1));

    // Offsets and raw direction from the latched sample
    assign dx_c  = {1'b0, xs_q} - CenterW;
    assign dy_c  = {1'b0, ys_q} - CenterW;
    assign adx   = dx_c[10] ? (~dx_c + 11'd1) : dx_c;
    assign ady   = dy_c[10] ? (~dy_c + 11'd1) : dy_c;
    assign x_def = (adx > DzW);
    assign y_def = (ady > DzW);

    always_comb begin
        raw_c = 4'b0000;
        // Larger magnitude wins; a tie goes to the y axis
        if (ady >= adx) begin
            if (y_def) raw_c = dy_c[10] ? 4'b0100 : 4'b1000;
        end else begin
            if (x_def) raw_c = dx_c[10] ? 4'b0010 : 4'b0001;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        changed_d = 1'b0;
        fault_d   = fault;
        xs_d      = xs_q;
        ys_d      = ys_q;
        dx_d      = dx;
        dy_d      = dy;
        raw_d     = raw_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        dir_d     = dir;
`ifdef JOY_AVG_EN
        xw_d      = xw_q;
        yw_d      = yw_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StWait;
                    start_d = 1'b1;
                    wait_d  = '0;
                end
            end
            StWait: begin
                // Data beats an expiry landing in the same cycle
                if (data_valid) begin
`ifdef JOY_AVG_EN
                    xw_d    = {xw_q[2:0], x_data_in};
                    yw_d    = {yw_q[2:0], y_data_in};
                    state_d = StAvg;
`else
                    xs_d    = x_data_in;
                    ys_d    = y_data_in;
                    state_d = StCalc;
`endif
                end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    fault_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
`ifdef JOY_AVG_EN
            StAvg: begin
                xs_d    = 10'(xsum >> 2);
                ys_d    = 10'(ysum >> 2);
                state_d = StCalc;
            end
`endif
            StCalc: begin
                dx_d    = dx_c;
                dy_d    = dy_c;
                raw_d   = raw_c;
                fault_d = 1'b0;
                state_d = StCommit;
            end
            StCommit: begin
                if (raw_q == cand_q) begin
                    cnt_d = (cnt_q >= StableW) ? StableW : cnt_q + 4'd1;
                end else begin
                    cand_d = raw_q;
                    cnt_d  = 4'd1;
                end
                if (cnt_d == StableW && cand_d != dir) begin
                    dir_d     = cand_d;
                    changed_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            wait_q      <= '0;
            adc_start   <= 1'b0;
            timeout     <= 1'b0;
            fault       <= 1'b0;
            dir_changed <= 1'b0;
            xs_q        <= '0;
            ys_q        <= '0;
            dx          <= '0;
            dy          <= '0;
            raw_q       <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            dir         <= '0;
`ifdef JOY_AVG_EN
            xw_q        <= {4{10'(CENTER)}};
            yw_q        <= {4{10'(CENTER)}};
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick ? '0 : tick_q + TickW'(1);
            wait_q      <= wait_d;
            adc_start   <= start_d;
            timeout     <= timeout_d;
            fault       <= fault_d;
            dir_changed <= changed_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            dx          <= dx_d;
            dy          <= dy_d;
            raw_q       <= raw_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            dir         <= dir_d;
`ifdef JOY_AVG_EN
            xw_q        <= xw_d;
            yw_q        <= yw_d;
`endif
        end
    end

endmodule
